imem_load_ctrl: RTL and testbench

//  Sequences writes into the IMEM shift-register instruction memory (64 x 16-bit words).

---
 rtl/imem_pkg.sv | 13 +
 rtl/rr_arb2.sv | 31 +++
 rtl/imem_load_ctrl.sv | 121 ++++++++++++
 tb/tb_imem_load_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared IMEM geometry and load-controller state encoding.
package imem_pkg;

  localparam int IMEM_WORD_W = 16;
  localparam int IMEM_DEPTH  = 64;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FULL  = 2'd1,
    FLUSH = 2'd2
  } imem_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins at once, and a tie goes to the
// port the pointer favours. The pointer moves to the other port after each accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic ptr_q;

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  // After a port-0 accept, favour port 1 next, and the other way round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr_q <= 1'b0;
    else if (advance_i)
      ptr_q <= grant_o[0];
  end

endmodule

// File: rtl/imem_load_ctrl.sv
// Writes words from two arbitrated sources into the IMEM shift register, tracks the fill
// level, and clears the memory by shifting in DEPTH zeros when a flush is requested.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int WORD_W = IMEM_WORD_W,
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [WORD_W-1:0] req_data0,
  input  logic [WORD_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  input  logic              flush_req,
  output logic              shift_enable,
  output logic [WORD_W-1:0] new_value,
  output logic [CNT_W-1:0]  word_count,
  output logic              full,
  output logic              busy
);

  imem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic              full_q, full_d;
  logic              busy_q, busy_d;
  logic              sh_q, sh_d;
  logic [WORD_W-1:0] nv_q, nv_d;

  logic [1:0]        grant;
  logic              load_en;
  logic              accept;
  logic [WORD_W-1:0] sel_data;

  // A flush request masks ready in the same cycle, so a word offered alongside it is not lost.
  assign load_en   = (state_q == LOAD) && !full_q && !flush_req;
  assign req_ready = load_en ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign sel_data  = req_ready[1] ? req_data1 : req_data0;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (req_valid),
    .advance_i (accept),
    .grant_o   (grant)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    full_d  = full_q;
    busy_d  = busy_q;
    sh_d    = 1'b0;
    nv_d    = nv_q;

    case (state_q)
      LOAD, FULL: begin
        if (flush_req) begin
          // The first zero shift goes out together with busy rising.
          state_d = FLUSH;
          busy_d  = 1'b1;
          sh_d    = 1'b1;
          nv_d    = '0;
          cnt_d   = '0;
          full_d  = 1'b0;
          fcnt_d  = CNT_W'(DEPTH - 1);
        end else if (accept) begin
          sh_d  = 1'b1;
          nv_d  = sel_data;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DEPTH - 1)) begin
            full_d  = 1'b1;
            state_d = FULL;
          end
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = LOAD;
          busy_d  = 1'b0;
        end else begin
          fcnt_d = fcnt_q - CNT_W'(1);
          sh_d   = 1'b1;
          nv_d   = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
      sh_q    <= 1'b0;
      nv_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
      sh_q    <= sh_d;
      nv_q    <= nv_d;
    end
  end

  assign shift_enable = sh_q;
  assign new_value    = nv_q;
  assign word_count   = cnt_q;
  assign full         = full_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl with a behavioural IMEM shift register.
module tb_imem_load_ctrl;

  localparam int WORD_W = 16;
  localparam int DEPTH  = 64;
  localparam int CNT_W  = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [WORD_W-1:0] req_data0;
  logic [WORD_W-1:0] req_data1;
  logic [1:0]        req_ready;
  logic              flush_req;
  logic              shift_enable;
  logic [WORD_W-1:0] new_value;
  logic [CNT_W-1:0]  word_count;
  logic              full;
  logic              busy;

  logic [DEPTH*WORD_W-1:0] imem_m;

  int nvec = 0;
  int nerr = 0;

  imem_load_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data0    (req_data0),
    .req_data1    (req_data1),
    .req_ready    (req_ready),
    .flush_req    (flush_req),
    .shift_enable (shift_enable),
    .new_value    (new_value),
    .word_count   (word_count),
    .full         (full),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst)
      imem_m <= '1;
    else if (shift_enable)
      imem_m <= {imem_m[(DEPTH-1)*WORD_W-1:0], new_value};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b00;
    req_data0 = '0;
    req_data1 = '0;
    flush_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_shift", 32'(shift_enable), 32'd0);
    chk("rst_value", 32'(new_value), 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_full",  32'(full), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at posedge+1 of the cycle in which busy should first be high.
  task automatic wait_flush(output int ncyc, output int nzero);
    ncyc  = 0;
    nzero = 0;
    while (busy && ncyc < 200) begin
      ncyc++;
      if (shift_enable && new_value == '0) nzero++;
      @(posedge clk);
      #1;
    end
  endtask

  int ncyc, nzero;
  logic [WORD_W-1:0] exp_w;

  initial begin
    // Test 1: single host word
    do_reset();
    req_valid = 2'b01;
    req_data0 = 16'hA5A5;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    chk("t1_shift", 32'(shift_enable), 32'd1);
    chk("t1_value", 32'(new_value), 32'hA5A5);
    chk("t1_count", 32'(word_count), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;

    // Test 2: both ports contend, strict alternation starting from port 0
    do_reset();
    req_valid = 2'b11;
    req_data0 = 16'h1111;
    req_data1 = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_onehot", 32'($onehot(req_ready)), 32'd1);
      exp_w = (i % 2 == 0) ? 16'h1111 : 16'h2222;
      @(posedge clk); #1;
      chk("t2_value", 32'(new_value), 32'(exp_w));
      @(negedge clk);
    end
    chk("t2_count", 32'(word_count), 32'd4);
    req_valid = 2'b00;

    // Test 3: fill to DEPTH from port 0
    do_reset();
    req_valid = 2'b01;
    for (int i = 0; i < DEPTH; i++) begin
      req_data0 = 16'h0100 + 16'(i);
      @(posedge clk); #1;
      if (i == DEPTH - 2) begin
        chk("t3_full63",  32'(full), 32'd0);
        chk("t3_count63", 32'(word_count), 32'd63);
      end
      @(negedge clk);
    end
    chk("t3_full",  32'(full), 32'd1);
    chk("t3_count", 32'(word_count), 32'd64);
    chk("t3_last",  32'(new_value), 32'h013F);
    req_data0 = 16'hDEAD;
    #1;
    chk("t3_stall_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("t3_no_shift", 32'(shift_enable), 32'd0);
    chk("t3_sat",      32'(word_count), 32'd64);

    // Test 4: flush from FULL
    @(negedge clk);
    req_valid = 2'b00;
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    chk("t4_busy_rise", 32'(busy), 32'd1);
    chk("t4_full_drop", 32'(full), 32'd0);
    wait_flush(ncyc, nzero);
    chk("t4_busy_len", 32'(ncyc), 32'd64);
    chk("t4_zero_cnt", 32'(nzero), 32'd64);
    chk("t4_count",    32'(word_count), 32'd0);
    chk("t4_full",     32'(full), 32'd0);
    chk("t4_imem_zero", 32'(imem_m == '0), 32'd1);
    @(negedge clk);
    req_valid = 2'b01;
    req_data0 = 16'h7777;
    #1;
    chk("t4_ready_back", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;

    // Test 5: flush and a debug word in the same cycle
    do_reset();
    req_valid = 2'b10;
    req_data1 = 16'hBEEF;
    flush_req = 1'b1;
    #1;
    chk("t5_ready_mask", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    flush_req = 1'b0;
    chk("t5_first_zero", 32'(new_value), 32'd0);
    wait_flush(ncyc, nzero);
    chk("t5_busy_len", 32'(ncyc), 32'd64);
    chk("t5_zero_cnt", 32'(nzero), 32'd64);
    chk("t5_ready_after", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    chk("t5_shift", 32'(shift_enable), 32'd1);
    chk("t5_value", 32'(new_value), 32'hBEEF);
    chk("t5_count", 32'(word_count), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;

    // Test 6: reset in the middle of a flush
    do_reset();
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
    end
    chk("t6_busy_mid", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_shift", 32'(shift_enable), 32'd0);
    chk("t6_busy",  32'(busy), 32'd0);
    chk("t6_count", 32'(word_count), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 2'b10;
    req_data1 = 16'hCAFE;
    #1;
    chk("t6_ready", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    chk("t6_acc_shift", 32'(shift_enable), 32'd1);
    chk("t6_acc_value", 32'(new_value), 32'hCAFE);
    chk("t6_acc_count", 32'(word_count), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
